alu_arbiter: RTL and testbench

Shares one `ALU8bit` instance between two independent requesters, such as the CPU8bit execute stage and a background address/flag unit. Each requester presents an operation with a valid/ready handshake. A round-robin arbiter grants one operation per cycle to the ALU. The combinational ALU result is registered into a single response slot, which is returned to a shared consumer tagged with the requester id and held under backpressure.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_arbiter_if.sv | 42 ++++
 rtl/ALU8bit.sv | 31 +++
 rtl/alu_arbiter.sv | 90 +++++++++
 tb/tb_alu_arbiter.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Widths, opcode encoding and slot state shared by the ALU, its arbiter and the port interface.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int SEL_W  = 4;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [SEL_W-1:0]  sel_t;

  localparam sel_t ALU_PASSB = 4'b0000;
  localparam sel_t ALU_NOTB  = 4'b0001;
  localparam sel_t ALU_AND   = 4'b0010;
  localparam sel_t ALU_OR    = 4'b0011;
  localparam sel_t ALU_XOR   = 4'b0100;
  localparam sel_t ALU_ADD   = 4'b0101;
  localparam sel_t ALU_SUB   = 4'b0110;
  localparam sel_t ALU_SHL   = 4'b0111;
  localparam sel_t ALU_SHR   = 4'b1000;
  localparam sel_t ALU_SRA   = 4'b1001;

  localparam sel_t ALU_SEL_MAX = 4'b1001;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  function automatic logic sel_unassigned(input sel_t sel);
    return sel > ALU_SEL_MAX;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Two requester channels and one response channel around the shared ALU.
interface alu_arbiter_if;
  import alu_pkg::*;

  logic  req0_valid;
  logic  req0_ready;
  sel_t  req0_sel;
  data_t req0_a;
  data_t req0_b;

  logic  req1_valid;
  logic  req1_ready;
  sel_t  req1_sel;
  data_t req1_a;
  data_t req1_b;

  logic  rsp_valid;
  logic  rsp_ready;
  logic  rsp_id;
  data_t rsp_c;
  logic  rsp_cmp;
  logic  rsp_err;

  // Requesters and response consumer.
  modport master (
    output req0_valid, req0_sel, req0_a, req0_b,
    output req1_valid, req1_sel, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_c, rsp_cmp, rsp_err
  );

  // The arbiter.
  modport slave (
    input  req0_valid, req0_sel, req0_a, req0_b,
    input  req1_valid, req1_sel, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_c, rsp_cmp, rsp_err
  );

endinterface

// File: rtl/ALU8bit.sv
// Combinational 8-bit ALU; cmp flags operand A strictly greater than B (unsigned).
module ALU8bit
  import alu_pkg::*;
(
  input  data_t a,
  input  data_t b,
  input  sel_t  sel,
  output data_t c,
  output logic  cmp
);

  always_comb begin
    c = '0;
    case (sel)
      ALU_PASSB: c = b;
      ALU_NOTB:  c = ~b;
      ALU_AND:   c = a & b;
      ALU_OR:    c = a | b;
      ALU_XOR:   c = a ^ b;
      ALU_ADD:   c = a + b;
      ALU_SUB:   c = a - b;
      ALU_SHL:   c = a << b;
      ALU_SHR:   c = a >> b;
      ALU_SRA:   c = data_t'($signed(a) >>> b);
      default:   c = '0;
    endcase
  end

  assign cmp = (a > b);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU8bit between two requesters; one registered response slot,
// loaded one edge after acceptance and held bit-stable while the consumer stalls.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter bit RR_INIT = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);

  slot_state_t state;
  logic        prio;
  logic        rsp_id_q;
  data_t       rsp_c_q;
  logic        rsp_cmp_q;
  logic        rsp_err_q;

  logic  accept;
  logic  gnt_vld;
  logic  gnt_id;
  sel_t  alu_sel;
  data_t alu_a;
  data_t alu_b;
  data_t alu_c;
  logic  alu_cmp;
  logic  op_err;

  // rst_n gates the grant so neither ready can assert while held in reset.
  always_comb begin
    accept  = (state == SLOT_EMPTY) || bus.rsp_ready;
    gnt_id  = (bus.req0_valid && bus.req1_valid) ? prio : bus.req1_valid;
    gnt_vld = rst_n && accept && (bus.req0_valid || bus.req1_valid);
  end

  assign bus.req0_ready = gnt_vld && !gnt_id;
  assign bus.req1_ready = gnt_vld && gnt_id;

  always_comb begin
    alu_sel = bus.req0_sel;
    alu_a   = bus.req0_a;
    alu_b   = bus.req0_b;
    if (gnt_id) begin
      alu_sel = bus.req1_sel;
      alu_a   = bus.req1_a;
      alu_b   = bus.req1_b;
    end
  end

  ALU8bit u_alu (
    .a   (alu_a),
    .b   (alu_b),
    .sel (alu_sel),
    .c   (alu_c),
    .cmp (alu_cmp)
  );

  assign op_err = sel_unassigned(alu_sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SLOT_EMPTY;
      prio      <= RR_INIT;
      rsp_id_q  <= 1'b0;
      rsp_c_q   <= '0;
      rsp_cmp_q <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      case (state)
        SLOT_EMPTY: if (gnt_vld) state <= SLOT_FULL;
        SLOT_FULL:  if (bus.rsp_ready && !gnt_vld) state <= SLOT_EMPTY;
      endcase
      if (gnt_vld) begin
        prio      <= !gnt_id;
        rsp_id_q  <= gnt_id;
        rsp_c_q   <= op_err ? '0 : alu_c;
        rsp_cmp_q <= op_err ? 1'b0 : alu_cmp;
        rsp_err_q <= op_err;
      end
    end
  end

  assign bus.rsp_valid = (state == SLOT_FULL);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_c     = rsp_c_q;
  assign bus.rsp_cmp   = rsp_cmp_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed scenarios plus randomized traffic against a behavioural model of the shared-ALU arbiter.
module tb_alu_arbiter;

  localparam bit RR = 1'b0;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  logic acc0;
  logic acc1;

  alu_arbiter_if bus ();

  alu_arbiter #(.RR_INIT(RR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU from the opcode table: returns {err, cmp, c}.
  function automatic logic [9:0] alu_ref(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
    logic [7:0] r;
    int sh;
    int sx;
    sh = int'(y);
    sx = int'(x) - (x[7] ? 256 : 0);
    r  = 8'h00;
    case (op)
      4'd0: r = y;
      4'd1: r = ~y;
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = x ^ y;
      4'd5: r = 8'((int'(x) + int'(y)) % 256);
      4'd6: r = 8'((int'(x) - int'(y) + 256) % 256);
      4'd7: r = (sh > 7) ? 8'h00 : 8'(int'(x) << sh);
      4'd8: r = (sh > 7) ? 8'h00 : 8'(int'(x) >> sh);
      4'd9: r = (sh > 7) ? {8{x[7]}} : 8'(sx >>> sh);
      default: return {1'b1, 1'b0, 8'h00};
    endcase
    return {1'b0, (x > y), r};
  endfunction

  // Behavioural model: one slot, a priority bit, grant rules straight from the description.
  logic       m_full;
  logic       m_id;
  logic [7:0] m_c;
  logic       m_cmp;
  logic       m_err;
  logic       m_prio;
  logic       m_go;
  logic       m_who;
  logic [9:0] m_res;

  assign m_go  = (!m_full || bus.rsp_ready) && (bus.req0_valid || bus.req1_valid);
  assign m_who = (bus.req0_valid && bus.req1_valid) ? m_prio : bus.req1_valid;
  assign m_res = m_who ? alu_ref(bus.req1_sel, bus.req1_a, bus.req1_b)
                       : alu_ref(bus.req0_sel, bus.req0_a, bus.req0_b);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_full <= 1'b0;
      m_id   <= 1'b0;
      m_c    <= 8'h00;
      m_cmp  <= 1'b0;
      m_err  <= 1'b0;
      m_prio <= RR;
    end else if (m_go) begin
      m_full <= 1'b1;
      m_id   <= m_who;
      m_err  <= m_res[9];
      m_cmp  <= m_res[8];
      m_c    <= m_res[7:0];
      m_prio <= !m_who;
    end else if (bus.rsp_ready) begin
      m_full <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check1("m_req0_ready", bus.req0_ready, m_go && !m_who);
      check1("m_req1_ready", bus.req1_ready, m_go && m_who);
      check1("m_rsp_valid", bus.rsp_valid, m_full);
      check1("m_rsp_id", bus.rsp_id, m_id);
      check8("m_rsp_c", bus.rsp_c, m_c);
      check1("m_rsp_cmp", bus.rsp_cmp, m_cmp);
      check1("m_rsp_err", bus.rsp_err, m_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_op(output logic v, output logic [3:0] s, output logic [7:0] x, output logic [7:0] y);
    v = ($urandom_range(0, 2) != 0);
    s = 4'($urandom_range(0, 15));
    x = 8'($urandom);
    y = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.rsp_ready  = 1'b1;
    bus.req1_valid = 1'b0;
    bus.req1_sel   = 4'h0;
    bus.req1_a     = 8'h00;
    bus.req1_b     = 8'h00;
    bus.req0_valid = 1'b1;
    bus.req0_sel   = 4'b0010;
    bus.req0_a     = 8'hF3;
    bus.req0_b     = 8'h25;

    // Reset state, then single request AND F3,25.
    repeat (2) @(posedge clk);
    #3;
    check1("rst_valid", bus.rsp_valid, 1'b0);
    check1("rst_id", bus.rsp_id, 1'b0);
    check8("rst_c", bus.rsp_c, 8'h00);
    check1("rst_cmp", bus.rsp_cmp, 1'b0);
    check1("rst_err", bus.rsp_err, 1'b0);
    check1("rst_rdy0", bus.req0_ready, 1'b0);
    rst_n = 1'b1;
    #1;
    check1("t1_rdy0", bus.req0_ready, 1'b1);
    tick();

    // req1 alone with NOT 0C.
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1;
    bus.req1_sel   = 4'b0001;
    bus.req1_b     = 8'h0C;
    #1;
    check1("t1_valid", bus.rsp_valid, 1'b1);
    check1("t1_id", bus.rsp_id, 1'b0);
    check8("t1_c", bus.rsp_c, 8'h21);
    check1("t1_cmp", bus.rsp_cmp, 1'b1);
    check1("t5_rdy1", bus.req1_ready, 1'b1);
    tick();

    // Contention: XOR A3^45 vs SHL A3 by 02.
    bus.req0_valid = 1'b1;
    bus.req0_sel   = 4'b0100;
    bus.req0_a     = 8'hA3;
    bus.req0_b     = 8'h45;
    bus.req1_sel   = 4'b0111;
    bus.req1_a     = 8'hA3;
    bus.req1_b     = 8'h02;
    #1;
    check8("t5_c", bus.rsp_c, 8'hF3);
    check1("t5_id", bus.rsp_id, 1'b1);
    check1("t5_rdy0", bus.req0_ready, 1'b1);
    check1("t5_rdy1_low", bus.req1_ready, 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end
      #1;
      check8("rr_c", bus.rsp_c, (k % 2 == 0) ? 8'hE6 : 8'h8C);
      check1("rr_id", bus.rsp_id, k % 2 == 1);
      check1("rr_valid", bus.rsp_valid, 1'b1);
      if (k < 3) check1("rr_rdy1", bus.req1_ready, k % 2 == 0);
      tick();
    end

    // Backpressure: SHR A3 by 02 held while SRA waits.
    bus.req0_valid = 1'b1;
    bus.req0_sel   = 4'b1000;
    bus.req0_a     = 8'hA3;
    bus.req0_b     = 8'h02;
    #1;
    check1("bp_rdy0", bus.req0_ready, 1'b1);
    tick();
    bus.req0_valid = 1'b0;
    bus.rsp_ready  = 1'b0;
    bus.req1_valid = 1'b1;
    bus.req1_sel   = 4'b1001;
    bus.req1_a     = 8'hA3;
    bus.req1_b     = 8'h02;
    for (int j = 0; j < 3; j++) begin
      #1;
      check1("bp_rdy1_low", bus.req1_ready, 1'b0);
      check8("bp_c_hold", bus.rsp_c, 8'h28);
      check1("bp_valid", bus.rsp_valid, 1'b1);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check1("bp_rdy1", bus.req1_ready, 1'b1);
    tick();
    bus.req1_valid = 1'b0;
    #1;
    check8("bp_c", bus.rsp_c, 8'hE8);
    check1("bp_id", bus.rsp_id, 1'b1);
    check1("bp_valid_kept", bus.rsp_valid, 1'b1);

    // Unassigned opcode.
    bus.req1_valid = 1'b1;
    bus.req1_sel   = 4'b1100;
    bus.req1_a     = 8'hFF;
    bus.req1_b     = 8'hFF;
    #1;
    check1("ua_rdy1", bus.req1_ready, 1'b1);
    tick();
    bus.req1_valid = 1'b0;
    #1;
    check1("ua_err", bus.rsp_err, 1'b1);
    check8("ua_c", bus.rsp_c, 8'h00);
    check1("ua_cmp", bus.rsp_cmp, 1'b0);
    check1("ua_valid", bus.rsp_valid, 1'b1);

    // Reset mid-operation with slot full and priority on req1.
    bus.req0_valid = 1'b1;
    bus.req0_sel   = 4'b0101;
    bus.req0_a     = 8'h10;
    bus.req0_b     = 8'h20;
    #1;
    check1("mr_rdy0", bus.req0_ready, 1'b1);
    tick();
    bus.rsp_ready  = 1'b0;
    bus.req0_sel   = 4'b0000;
    bus.req0_b     = 8'h11;
    bus.req1_valid = 1'b1;
    bus.req1_sel   = 4'b0000;
    bus.req1_b     = 8'h22;
    #1;
    check8("mr_c", bus.rsp_c, 8'h30);
    check1("mr_valid", bus.rsp_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check1("mr_valid_clr", bus.rsp_valid, 1'b0);
    check8("mr_c_clr", bus.rsp_c, 8'h00);
    check1("mr_rdy0_low", bus.req0_ready, 1'b0);
    check1("mr_rdy1_low", bus.req1_ready, 1'b0);
    tick();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    #1;
    check1("mr_rdy0_win", bus.req0_ready, 1'b1);
    check1("mr_rdy1_lose", bus.req1_ready, 1'b0);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    #1;
    check8("mr_first_c", bus.rsp_c, 8'h11);
    check1("mr_first_id", bus.rsp_id, 1'b0);

    // Randomized traffic; requesters hold operations until accepted.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      acc0 = bus.req0_valid && bus.req0_ready;
      acc1 = bus.req1_valid && bus.req1_ready;
      @(posedge clk);
      #1;
      if (!bus.req0_valid || acc0) rand_op(bus.req0_valid, bus.req0_sel, bus.req0_a, bus.req0_b);
      if (!bus.req1_valid || acc1) rand_op(bus.req1_valid, bus.req1_sel, bus.req1_a, bus.req1_b);
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end

    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b1;
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
